// File: rtl/snake_pkg.sv
// Shared defaults, FSM encoding and helpers for the snake frame shadow latch.
package snake_pkg;

  localparam int unsigned MaxLenDef = 33;
  localparam int unsigned XwDef     = 10;
  localparam int unsigned YwDef     = 9;
  localparam int unsigned LwDef     = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StPending = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/snake_state_bank.sv
// Scalar + body register bank: per-slot segment write port and whole-bank load.
module snake_state_bank #(
  parameter int unsigned MAX_LEN = 33,
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 9,
  parameter int unsigned LW      = 8
) (
  input  logic                  clk_pix,
  input  logic                  rst_n,
  input  logic                  seg_we,
  input  logic [LW-1:0]         seg_idx,
  input  logic [XW-1:0]         seg_x,
  input  logic [YW-1:0]         seg_y,
  input  logic                  scal_we,
  input  logic [XW-1:0]         wr_head_x,
  input  logic [YW-1:0]         wr_head_y,
  input  logic [XW-1:0]         wr_apple_x,
  input  logic [YW-1:0]         wr_apple_y,
  input  logic [LW-1:0]         wr_len,
  input  logic                  body_load,
  input  logic [MAX_LEN*XW-1:0] wr_body_x,
  input  logic [MAX_LEN*YW-1:0] wr_body_y,
  output logic [XW-1:0]         head_x_q,
  output logic [YW-1:0]         head_y_q,
  output logic [XW-1:0]         apple_x_q,
  output logic [YW-1:0]         apple_y_q,
  output logic [LW-1:0]         len_q,
  output logic [MAX_LEN*XW-1:0] body_x,
  output logic [MAX_LEN*YW-1:0] body_y
);

  logic [XW-1:0] body_x_q [MAX_LEN];
  logic [YW-1:0] body_y_q [MAX_LEN];

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      head_x_q  <= '0;
      head_y_q  <= '0;
      apple_x_q <= '0;
      apple_y_q <= '0;
      len_q     <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x_q[i] <= '0;
        body_y_q[i] <= '0;
      end
    end else begin
      if (scal_we) begin
        head_x_q  <= wr_head_x;
        head_y_q  <= wr_head_y;
        apple_x_q <= wr_apple_x;
        apple_y_q <= wr_apple_y;
        len_q     <= wr_len;
      end
      for (int i = 0; i < MAX_LEN; i++) begin
        if (body_load) begin
          body_x_q[i] <= wr_body_x[i*XW +: XW];
          body_y_q[i] <= wr_body_y[i*YW +: YW];
        end else if (seg_we && (seg_idx == LW'(i))) begin
          body_x_q[i] <= seg_x;
          body_y_q[i] <= seg_y;
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : gen_bus
    assign body_x[g*XW +: XW] = body_x_q[g];
    assign body_y[g*YW +: YW] = body_y_q[g];
  end

endmodule

// File: rtl/snake_frame_shadow.sv
// Double-buffered snake state: serial shadow load, atomic commit, swap to active on frame_start.
module snake_frame_shadow
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = MaxLenDef,
  parameter int unsigned XW      = XwDef,
  parameter int unsigned YW      = YwDef,
  parameter int unsigned LW      = LwDef
) (
  input  logic                  clk_pix,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  upd_start,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  input  logic [XW-1:0]         seg_x,
  input  logic [YW-1:0]         seg_y,
  input  logic                  upd_commit,
  input  logic [XW-1:0]         head_x,
  input  logic [YW-1:0]         head_y,
  input  logic [XW-1:0]         apple_x,
  input  logic [YW-1:0]         apple_y,
  input  logic [LW-1:0]         snake_len,
  output logic [XW-1:0]         head_x_d,
  output logic [YW-1:0]         head_y_d,
  output logic [XW-1:0]         apple_x_d,
  output logic [YW-1:0]         apple_y_d,
  output logic [LW-1:0]         snake_len_d,
  output logic [MAX_LEN*XW-1:0] body_bus_x_d,
  output logic [MAX_LEN*YW-1:0] body_bus_y_d,
  output logic                  frame_fresh,
  output logic [7:0]            drop_cnt
);

  localparam logic [LW-1:0] MaxCnt = LW'(MAX_LEN);

  state_e        state_q;
  logic [LW-1:0] seg_cnt_q;
  logic [7:0]    drop_cnt_q;
  logic          frame_fresh_q;

  logic          seg_wr, commit, swap;
  logic [LW-1:0] cnt_incl, shadow_len;

  logic [XW-1:0]         sh_head_x, sh_apple_x;
  logic [YW-1:0]         sh_head_y, sh_apple_y;
  logic [LW-1:0]         sh_len;
  logic [MAX_LEN*XW-1:0] sh_body_x;
  logic [MAX_LEN*YW-1:0] sh_body_y;

  always_comb begin
    seg_ready  = (state_q == StLoad) && (seg_cnt_q < MaxCnt);
    seg_wr     = seg_valid && seg_ready;
    // A restart in the same cycle as a commit wins; the snapshot is abandoned.
    commit     = (state_q == StLoad) && upd_commit && !upd_start;
    swap       = (state_q == StPending) && frame_start;
    cnt_incl   = seg_cnt_q + LW'(seg_wr);
    shadow_len = (snake_len < cnt_incl) ? snake_len : cnt_incl;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      seg_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      frame_fresh_q <= 1'b0;
    end else begin
      if (frame_start) frame_fresh_q <= swap;
      case (state_q)
        StIdle: begin
          if (upd_start) begin
            state_q   <= StLoad;
            seg_cnt_q <= '0;
          end
        end
        StLoad: begin
          if (upd_start) begin
            seg_cnt_q <= '0;
          end else begin
            if (seg_wr) seg_cnt_q <= seg_cnt_q + 1'b1;
            if (upd_commit) state_q <= StPending;
          end
        end
        StPending: begin
          if (frame_start) begin
            state_q   <= upd_start ? StLoad : StIdle;
            seg_cnt_q <= '0;
          end else if (upd_start) begin
            state_q    <= StLoad;
            seg_cnt_q  <= '0;
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  snake_state_bank #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) u_shadow (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .seg_we     (seg_wr),
    .seg_idx    (seg_cnt_q),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .scal_we    (commit),
    .wr_head_x  (head_x),
    .wr_head_y  (head_y),
    .wr_apple_x (apple_x),
    .wr_apple_y (apple_y),
    .wr_len     (shadow_len),
    .body_load  (1'b0),
    .wr_body_x  ('0),
    .wr_body_y  ('0),
    .head_x_q   (sh_head_x),
    .head_y_q   (sh_head_y),
    .apple_x_q  (sh_apple_x),
    .apple_y_q  (sh_apple_y),
    .len_q      (sh_len),
    .body_x     (sh_body_x),
    .body_y     (sh_body_y)
  );

  snake_state_bank #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) u_active (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .seg_we     (1'b0),
    .seg_idx    ('0),
    .seg_x      ('0),
    .seg_y      ('0),
    .scal_we    (swap),
    .wr_head_x  (sh_head_x),
    .wr_head_y  (sh_head_y),
    .wr_apple_x (sh_apple_x),
    .wr_apple_y (sh_apple_y),
    .wr_len     (sh_len),
    .body_load  (swap),
    .wr_body_x  (sh_body_x),
    .wr_body_y  (sh_body_y),
    .head_x_q   (head_x_d),
    .head_y_q   (head_y_d),
    .apple_x_q  (apple_x_d),
    .apple_y_q  (apple_y_d),
    .len_q      (snake_len_d),
    .body_x     (body_bus_x_d),
    .body_y     (body_bus_y_d)
  );

  assign frame_fresh = frame_fresh_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_snake_frame_shadow.sv
// Directed self-checking bench for snake_frame_shadow with default parameters.
module tb_snake_frame_shadow;

  localparam int unsigned MAX_LEN = 33;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned LW = 8;

  logic clk_pix = 1'b0;
  logic rst_n, frame_start, upd_start, seg_valid, seg_ready, upd_commit;
  logic [XW-1:0] seg_x, head_x, apple_x, head_x_d, apple_x_d;
  logic [YW-1:0] seg_y, head_y, apple_y, head_y_d, apple_y_d;
  logic [LW-1:0] snake_len, snake_len_d;
  logic [MAX_LEN*XW-1:0] body_bus_x_d;
  logic [MAX_LEN*YW-1:0] body_bus_y_d;
  logic frame_fresh;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  snake_frame_shadow dut (
    .clk_pix      (clk_pix),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .upd_start    (upd_start),
    .seg_valid    (seg_valid),
    .seg_ready    (seg_ready),
    .seg_x        (seg_x),
    .seg_y        (seg_y),
    .upd_commit   (upd_commit),
    .head_x       (head_x),
    .head_y       (head_y),
    .apple_x      (apple_x),
    .apple_y      (apple_y),
    .snake_len    (snake_len),
    .head_x_d     (head_x_d),
    .head_y_d     (head_y_d),
    .apple_x_d    (apple_x_d),
    .apple_y_d    (apple_y_d),
    .snake_len_d  (snake_len_d),
    .body_bus_x_d (body_bus_x_d),
    .body_bus_y_d (body_bus_y_d),
    .frame_fresh  (frame_fresh),
    .drop_cnt     (drop_cnt)
  );

  function automatic logic [XW-1:0] slot_x(input int i);
    return body_bus_x_d[i*XW +: XW];
  endfunction

  function automatic logic [YW-1:0] slot_y(input int i);
    return body_bus_y_d[i*YW +: YW];
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_start();
    upd_start = 1'b1;
    tick();
    upd_start = 1'b0;
  endtask

  task automatic send_seg(input int x, input int y);
    seg_valid = 1'b1;
    seg_x = XW'(x);
    seg_y = YW'(y);
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic do_commit(input int len, input int hx, input int hy, input int ax, input int ay);
    upd_commit = 1'b1;
    snake_len = LW'(len);
    head_x = XW'(hx);
    head_y = YW'(hy);
    apple_x = XW'(ax);
    apple_y = YW'(ay);
    tick();
    upd_commit = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (snake_len_d !== 8'd0) begin errors++; $display("FAIL rst_len got %0d want 0", snake_len_d); end
    checks++; if (body_bus_x_d !== '0) begin errors++; $display("FAIL rst_body_x got %0h want 0", body_bus_x_d); end
    checks++; if ({head_x_d, head_y_d, apple_x_d, apple_y_d} !== '0) begin errors++; $display("FAIL rst_scalars got %0h want 0", {head_x_d, head_y_d, apple_x_d, apple_y_d}); end
    checks++; if ({seg_ready, frame_fresh, drop_cnt} !== '0) begin errors++; $display("FAIL rst_flags got %0h want 0", {seg_ready, frame_fresh, drop_cnt}); end
    rst_n = 1'b1;
    tick();
    // Load the active bank, then reset in the middle of the next load.
    do_start();
    send_seg(5, 5);
    do_commit(1, 5, 5, 1, 1);
    do_frame();
    checks++; if (snake_len_d !== 8'd1) begin errors++; $display("FAIL pre_rst_len got %0d want 1", snake_len_d); end
    do_start();
    send_seg(6, 6);
    rst_n = 1'b0;
    #1;
    checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL midload_ready got %0b want 0", seg_ready); end
    checks++; if ({snake_len_d, frame_fresh, body_bus_x_d} !== '0) begin errors++; $display("FAIL midload_clear got %0h want 0", {snake_len_d, frame_fresh, body_bus_x_d}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL post_rst_idle_ready got %0b want 0", seg_ready); end
    do_frame();
    checks++; if ({snake_len_d, frame_fresh} !== '0) begin errors++; $display("FAIL post_rst_no_swap got %0h want 0", {snake_len_d, frame_fresh}); end
  endtask

  task automatic test_basic();
    do_start();
    checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", seg_ready); end
    send_seg(10, 20);
    send_seg(11, 20);
    send_seg(12, 20);
    do_commit(3, 12, 20, 40, 30);
    checks++; if (snake_len_d !== 8'd0) begin errors++; $display("FAIL basic_before_frame got %0d want 0", snake_len_d); end
    do_frame();
    checks++; if (snake_len_d !== 8'd3) begin errors++; $display("FAIL basic_len got %0d want 3", snake_len_d); end
    checks++; if (slot_x(1) !== 10'd11 || slot_y(1) !== 9'd20) begin errors++; $display("FAIL basic_slot1 got (%0d,%0d) want (11,20)", slot_x(1), slot_y(1)); end
    checks++; if (slot_x(0) !== 10'd10 || slot_x(2) !== 10'd12) begin errors++; $display("FAIL basic_slot02 got (%0d,%0d) want (10,12)", slot_x(0), slot_x(2)); end
    checks++; if (head_x_d !== 10'd12 || apple_x_d !== 10'd40 || apple_y_d !== 9'd30) begin errors++; $display("FAIL basic_scalars got %0d %0d %0d want 12 40 30", head_x_d, apple_x_d, apple_y_d); end
    checks++; if (frame_fresh !== 1'b1) begin errors++; $display("FAIL basic_fresh got %0b want 1", frame_fresh); end
    tick();
    checks++; if (frame_fresh !== 1'b1) begin errors++; $display("FAIL basic_fresh_hold got %0b want 1", frame_fresh); end
  endtask

  task automatic test_overflow();
    int acc = 0;
    do_start();
    for (int i = 0; i < 40; i++) begin
      seg_valid = 1'b1;
      seg_x = XW'(i);
      seg_y = YW'(i + 100);
      if (seg_ready) acc++;
      tick();
    end
    seg_valid = 1'b0;
    checks++; if (acc != 33) begin errors++; $display("FAIL ovf_accepts got %0d want 33", acc); end
    checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %0b want 0", seg_ready); end
    do_commit(40, 1, 2, 3, 4);
    do_frame();
    checks++; if (snake_len_d !== 8'd33) begin errors++; $display("FAIL ovf_len got %0d want 33", snake_len_d); end
    checks++; if (slot_x(32) !== 10'd32 || slot_y(32) !== 9'd132) begin errors++; $display("FAIL ovf_slot32 got (%0d,%0d) want (32,132)", slot_x(32), slot_y(32)); end
  endtask

  task automatic test_short();
    do_start();
    send_seg(7, 8);
    send_seg(9, 10);
    do_commit(5, 0, 0, 0, 0);
    do_frame();
    checks++; if (snake_len_d !== 8'd2) begin errors++; $display("FAIL short_len got %0d want 2", snake_len_d); end
    checks++; if (slot_x(1) !== 10'd9 || slot_y(1) !== 9'd10) begin errors++; $display("FAIL short_slot1 got (%0d,%0d) want (9,10)", slot_x(1), slot_y(1)); end
    checks++; if (slot_x(2) !== 10'd2 || slot_y(2) !== 9'd102) begin errors++; $display("FAIL short_stale2 got (%0d,%0d) want (2,102)", slot_x(2), slot_y(2)); end
  endtask

  task automatic test_seg_commit();
    do_start();
    send_seg(1, 1);
    seg_valid = 1'b1;
    seg_x = 10'd2;
    seg_y = 9'd2;
    do_commit(9, 0, 0, 0, 0);
    seg_valid = 1'b0;
    do_frame();
    checks++; if (snake_len_d !== 8'd2) begin errors++; $display("FAIL segcommit_len got %0d want 2", snake_len_d); end
    checks++; if (slot_y(1) !== 9'd2) begin errors++; $display("FAIL segcommit_slot1 got %0d want 2", slot_y(1)); end
  endtask

  task automatic test_drop();
    do_start();
    do_commit(0, 0, 0, 0, 0);
    do_start();
    do_commit(0, 0, 0, 0, 0);
    do_start();
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_two got %0d want 2", drop_cnt); end
    do_commit(0, 0, 0, 0, 0);
    frame_start = 1'b1;
    upd_start = 1'b1;
    tick();
    frame_start = 1'b0;
    upd_start = 1'b0;
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_swap_start got %0d want 2", drop_cnt); end
    checks++; if (frame_fresh !== 1'b1 || seg_ready !== 1'b1) begin errors++; $display("FAIL swap_start_state got fresh=%0b ready=%0b want 1 1", frame_fresh, seg_ready); end
    for (int i = 0; i < 252; i++) begin
      do_commit(0, 0, 0, 0, 0);
      do_start();
    end
    checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254 got %0d want 254", drop_cnt); end
    for (int i = 0; i < 46; i++) begin
      do_commit(0, 0, 0, 0, 0);
      do_start();
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
    do_commit(0, 0, 0, 0, 0);
    do_frame();
  endtask

  task automatic test_coincidence();
    do_start();
    send_seg(3, 4);
    frame_start = 1'b1;
    do_commit(1, 0, 0, 0, 0);
    frame_start = 1'b0;
    checks++; if (frame_fresh !== 1'b0 || snake_len_d !== 8'd0) begin errors++; $display("FAIL coinc_no_swap got fresh=%0b len=%0d want 0 0", frame_fresh, snake_len_d); end
    do_frame();
    checks++; if (snake_len_d !== 8'd1 || slot_x(0) !== 10'd3 || slot_y(0) !== 9'd4) begin errors++; $display("FAIL coinc_swap got len=%0d (%0d,%0d) want 1 (3,4)", snake_len_d, slot_x(0), slot_y(0)); end
    checks++; if (frame_fresh !== 1'b1) begin errors++; $display("FAIL coinc_fresh got %0b want 1", frame_fresh); end
    do_frame();
    checks++; if (frame_fresh !== 1'b0 || snake_len_d !== 8'd1 || slot_x(0) !== 10'd3) begin errors++; $display("FAIL idle_frame got fresh=%0b len=%0d x0=%0d want 0 1 3", frame_fresh, snake_len_d, slot_x(0)); end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    upd_start = 1'b0;
    seg_valid = 1'b0;
    upd_commit = 1'b0;
    seg_x = '0;
    seg_y = '0;
    head_x = '0;
    head_y = '0;
    apple_x = '0;
    apple_y = '0;
    snake_len = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_short();
    test_seg_commit();
    test_drop();
    test_coincidence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
